// File: rtl/painter_pkg.sv
// Painter constants and FSM state encoding.
package painter_pkg;
  localparam int         SHEET_W     = 2448;
  localparam logic [7:0] TRANSPARENT = 8'h00;
  localparam int         FB_AW       = 19;
  localparam int         ROM_AW      = 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SCAN,
    S_DRAW,
    S_DRAIN
  } state_t;
endpackage

// File: rtl/runner_pkg.sv
// Shared game-runner types: per-slot sprite-sheet rectangles and signed screen positions.
package runner_pkg;
  localparam int RENDER_SLOTS = 32;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] w;
    logic [11:0] h;
  } sprite_t;

  typedef struct packed {
    logic signed [12:0] x;
    logic signed [12:0] y;
  } pos_t;
endpackage

// File: rtl/painter_blit.sv
// Per-slot sprite walker: row-major sheet reads plus a one-stage register that
// carries each read's destination to the cycle its ROM data arrives.
module painter_blit
  import painter_pkg::*;
  import runner_pkg::*;
#(
  parameter int FB_W = 1280,
  parameter int FB_H = 300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  sprite_t           spr,
  input  pos_t              dst,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              last,
  output logic              wr_pend,
  output logic              wr_vis,
  output logic [FB_AW-1:0]  wr_addr
);
  localparam logic signed [12:0] FB_W_S = 13'(FB_W);
  localparam logic signed [12:0] FB_H_S = 13'(FB_H);

  sprite_t            spr_q;
  pos_t               dst_q;
  logic [11:0]        col;
  logic [11:0]        row;
  logic [11:0]        sx;
  logic [11:0]        sy;
  logic signed [12:0] dx;
  logic signed [12:0] dy;
  logic               vis_now;
  logic [FB_AW-1:0]   addr_now;

  always_comb begin
    sx       = spr_q.x + col;
    sy       = spr_q.y + row;
    dx       = dst_q.x + $signed({1'b0, col});
    dy       = dst_q.y + $signed({1'b0, row});
    vis_now  = !dx[12] && (dx < FB_W_S) && !dy[12] && (dy < FB_H_S);
    // Only form an address for on-screen pixels so clipped ones never wrap.
    addr_now = vis_now ? (FB_AW'(dy[11:0]) * FB_AW'(FB_W) + FB_AW'(dx[11:0])) : '0;
    rom_addr = step ? (ROM_AW'(sy) * ROM_AW'(SHEET_W) + ROM_AW'(sx)) : '0;
    last     = (col == spr_q.w - 12'd1) && (row == spr_q.h - 12'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spr_q   <= '0;
      dst_q   <= '0;
      col     <= '0;
      row     <= '0;
      wr_pend <= 1'b0;
      wr_vis  <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_pend <= step;
      if (step) begin
        wr_vis  <= vis_now;
        wr_addr <= addr_now;
      end
      if (load) begin
        spr_q <= spr;
        dst_q <= dst;
        col   <= '0;
        row   <= '0;
      end else if (step) begin
        if (col == spr_q.w - 12'd1) begin
          col <= '0;
          row <= row + 12'd1;
        end else begin
          col <= col + 12'd1;
        end
      end
    end
  end
endmodule

// File: rtl/painter.sv
// Frame painter: clears the framebuffer, then blits every non-empty render slot in index order.
module painter
  import painter_pkg::*;
  import runner_pkg::*;
#(
  parameter int         FB_W = 1280,
  parameter int         FB_H = 300,
  parameter logic [7:0] BG   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  sprite_t           sprite [RENDER_SLOTS],
  input  pos_t              pos    [RENDER_SLOTS],
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              fb_we,
  output logic [FB_AW-1:0]  fb_addr,
  output logic [7:0]        fb_data,
  output logic              busy,
  output logic              painter_finished,
  output state_t            dbg_state
);
  localparam int              SW      = $clog2(RENDER_SLOTS);
  localparam logic [FB_AW-1:0] CLR_END = FB_AW'(FB_W * FB_H - 1);
  localparam logic [SW-1:0]   SLOT_END = SW'(RENDER_SLOTS - 1);

  state_t           state, state_n;
  logic [FB_AW-1:0] clr_cnt;
  logic [SW-1:0]    slot;
  logic             accept, load, step, slot_adv, slot_empty, last_slot;
  logic             blit_last, wr_pend, wr_vis, draw_we;
  logic [FB_AW-1:0] wr_addr;

  painter_blit #(.FB_W(FB_W), .FB_H(FB_H)) u_blit (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .spr      (sprite[slot]),
    .dst      (pos[slot]),
    .rom_addr (rom_addr),
    .last     (blit_last),
    .wr_pend  (wr_pend),
    .wr_vis   (wr_vis),
    .wr_addr  (wr_addr)
  );

  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    slot_adv   = 1'b0;
    slot_empty = (sprite[slot].w == 12'd0) || (sprite[slot].h == 12'd0);
    last_slot  = (slot == SLOT_END);
    case (state)
      S_IDLE: if (frame_start) begin
        accept  = 1'b1;
        state_n = S_CLEAR;
      end
      S_CLEAR: if (clr_cnt == CLR_END) state_n = S_SCAN;
      S_SCAN: begin
        load = 1'b1;
        if (!slot_empty) state_n = S_DRAW;
        else if (last_slot) state_n = S_DRAIN;
        else slot_adv = 1'b1;
      end
      S_DRAW: begin
        step = 1'b1;
        if (blit_last) begin
          if (last_slot) state_n = S_DRAIN;
          else begin
            state_n  = S_SCAN;
            slot_adv = 1'b1;
          end
        end
      end
      S_DRAIN: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // The pending blit write lands in whatever state follows DRAW (SCAN or DRAIN).
  always_comb begin
    draw_we   = wr_pend && wr_vis && (rom_data != TRANSPARENT);
    busy      = (state != S_IDLE);
    dbg_state = state;
    fb_we     = 1'b0;
    fb_addr   = '0;
    fb_data   = 8'h00;
    if (state == S_CLEAR) begin
      fb_we   = 1'b1;
      fb_addr = clr_cnt;
      fb_data = BG;
    end else if (draw_we) begin
      fb_we   = 1'b1;
      fb_addr = wr_addr;
      fb_data = rom_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      clr_cnt          <= '0;
      slot             <= '0;
      painter_finished <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        clr_cnt          <= '0;
        slot             <= '0;
        painter_finished <= 1'b0;
      end else begin
        if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
        if (slot_adv) slot <= slot + 1'b1;
        if (state == S_DRAIN) painter_finished <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_painter.sv
// Directed bench for painter on a 16x8 framebuffer with a synchronous ROM model.
module tb_painter;
  import painter_pkg::*;
  import runner_pkg::*;

  localparam int         FB_W = 16;
  localparam int         FB_H = 8;
  localparam logic [7:0] BG   = 8'h3C;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              frame_start = 1'b0;
  sprite_t           sprite [RENDER_SLOTS];
  pos_t              pos    [RENDER_SLOTS];
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data = 8'h00;
  logic              fb_we;
  logic [FB_AW-1:0]  fb_addr;
  logic [7:0]        fb_data;
  logic              busy;
  logic              painter_finished;
  state_t            dbg_state;

  painter #(.FB_W(FB_W), .FB_H(FB_H), .BG(BG)) dut (
    .clk              (clk),
    .rst              (rst),
    .frame_start      (frame_start),
    .sprite           (sprite),
    .pos              (pos),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .fb_we            (fb_we),
    .fb_addr          (fb_addr),
    .fb_data          (fb_data),
    .busy             (busy),
    .painter_finished (painter_finished),
    .dbg_state        (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- environment models ----------------
  function automatic logic [7:0] rom_fn(input logic [ROM_AW-1:0] a);
    if (a <= 18'd2) return 8'h05;
    if (a == 18'd100) return 8'h00;
    return {1'b1, a[6:0]};
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  logic [7:0] fb_mem [FB_W*FB_H];
  always @(posedge clk) if (fb_we) fb_mem[fb_addr[6:0]] <= fb_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor logs ----------------
  logic [FB_AW-1:0]  wr_addr_q [$];
  logic [7:0]        wr_data_q [$];
  int                wr_cyc_q  [$];
  logic [ROM_AW-1:0] rd_addr_q [$];
  int                rd_cyc_q  [$];
  int                clr_seen, clr_err, fin_rises;
  logic              fin_prev;
  logic              busy_c1;

  always @(negedge clk) begin
    if (fb_we && dbg_state == S_CLEAR) begin
      if (fb_addr != FB_AW'(clr_seen) || fb_data != BG) clr_err++;
      clr_seen++;
    end else if (fb_we) begin
      wr_addr_q.push_back(fb_addr);
      wr_data_q.push_back(fb_data);
      wr_cyc_q.push_back(cyc);
    end
    if (dbg_state == S_DRAW) begin
      rd_addr_q.push_back(rom_addr);
      rd_cyc_q.push_back(cyc);
    end
    if (painter_finished && !fin_prev) fin_rises++;
    fin_prev = painter_finished;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    rd_addr_q.delete(); rd_cyc_q.delete();
    clr_seen = 0; clr_err = 0; fin_rises = 0; fin_prev = 1'b0;
  endtask

  task automatic clear_slots();
    for (int i = 0; i < RENDER_SLOTS; i++) begin
      sprite[i] = '0;
      pos[i]    = '0;
    end
  endtask

  // Returns the number of rising edges from acceptance until painter_finished is seen.
  task automatic run_frame(output int n);
    @(negedge clk) frame_start = 1'b1;
    @(posedge clk);
    clear_logs();
    n = 1;
    @(negedge clk);
    frame_start = 1'b0;
    busy_c1 = busy;
    while (!painter_finished && n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] got [6];
    got[0] = 32'(busy); got[1] = 32'(painter_finished); got[2] = 32'(fb_we);
    got[3] = 32'(fb_addr); got[4] = 32'(fb_data); got[5] = 32'(rom_addr);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== 32'd0) begin
        errors++;
        $display("FAIL reset_out%0d got %0h exp 0", i, got[i]);
      end
    end
  endtask

  task automatic test_empty_frame();
    int n;
    clear_slots();
    run_frame(n);
    checks++; if (n !== 162) begin errors++; $display("FAIL empty_cycles got %0d exp 162", n); end
    checks++; if (busy_c1 !== 1'b1) begin errors++; $display("FAIL empty_busy_c1 got %b exp 1", busy_c1); end
    checks++; if (clr_seen !== 128) begin errors++; $display("FAIL empty_clr_cnt got %0d exp 128", clr_seen); end
    checks++; if (clr_err !== 0) begin errors++; $display("FAIL empty_clr_seq got %0d exp 0", clr_err); end
    checks++; if (wr_addr_q.size() !== 0) begin errors++; $display("FAIL empty_writes got %0d exp 0", wr_addr_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy_end got %b exp 0", busy); end
    checks++; if (fb_mem[127] !== BG) begin errors++; $display("FAIL empty_fb127 got %0h exp %0h", fb_mem[127], BG); end
  endtask

  task automatic test_blit();
    int n;
    logic [FB_AW-1:0]  exp_q [$];
    logic [ROM_AW-1:0] exp_rd [4];
    logic [7:0]        exp_d  [4];
    exp_q = '{19'd20, 19'd21, 19'd36, 19'd37};
    exp_rd[0] = 18'd4906; exp_rd[1] = 18'd4907; exp_rd[2] = 18'd7354; exp_rd[3] = 18'd7355;
    exp_d[0] = 8'hAA; exp_d[1] = 8'hAB; exp_d[2] = 8'hBA; exp_d[3] = 8'hBB;
    clear_slots();
    sprite[3] = '{x: 12'd10, y: 12'd2, w: 12'd2, h: 12'd2};
    pos[3]    = '{x: 13'sd4, y: 13'sd1};
    run_frame(n);
    checks++; if (n !== 166) begin errors++; $display("FAIL blit_cycles got %0d exp 166", n); end
    checks++;
    if (wr_addr_q.size() !== 4 || rd_addr_q.size() !== 4) begin
      errors++;
      $display("FAIL blit_count got wr %0d rd %0d exp 4 4", wr_addr_q.size(), rd_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (rd_addr_q[i] !== exp_rd[i]) begin errors++; $display("FAIL blit_rd%0d got %0d exp %0d", i, rd_addr_q[i], exp_rd[i]); end
        checks++; if (wr_addr_q[i] !== exp_q[i]) begin errors++; $display("FAIL blit_wr%0d got %0d exp %0d", i, wr_addr_q[i], exp_q[i]); end
        checks++; if (wr_data_q[i] !== exp_d[i]) begin errors++; $display("FAIL blit_data%0d got %0h exp %0h", i, wr_data_q[i], exp_d[i]); end
        checks++; if (wr_cyc_q[i] !== rd_cyc_q[i] + 1) begin errors++; $display("FAIL blit_lat%0d got %0d exp %0d", i, wr_cyc_q[i], rd_cyc_q[i] + 1); end
      end
    end
  endtask

  task automatic test_clip();
    int n;
    clear_slots();
    sprite[0] = '{x: 12'd0, y: 12'd0, w: 12'd2, h: 12'd2};
    pos[0]    = '{x: -13'sd1, y: 13'sd7};
    run_frame(n);
    checks++; if (n !== 166) begin errors++; $display("FAIL clip_cycles got %0d exp 166", n); end
    checks++; if (rd_addr_q.size() !== 4) begin errors++; $display("FAIL clip_reads got %0d exp 4", rd_addr_q.size()); end
    checks++;
    if (wr_addr_q.size() !== 1) begin
      errors++;
      $display("FAIL clip_writes got %0d exp 1", wr_addr_q.size());
    end else begin
      checks++; if (wr_addr_q[0] !== 19'd112) begin errors++; $display("FAIL clip_addr got %0d exp 112", wr_addr_q[0]); end
    end
    checks++; if (fb_mem[112] !== 8'h05) begin errors++; $display("FAIL clip_fb112 got %0h exp 05", fb_mem[112]); end
  endtask

  task automatic test_overlap();
    int n;
    logic [7:0] exp_fb [5];
    exp_fb[0] = 8'h05; exp_fb[1] = 8'h05; exp_fb[2] = 8'hE5; exp_fb[3] = 8'hE6; exp_fb[4] = BG;
    clear_slots();
    sprite[2] = '{x: 12'd0,   y: 12'd0, w: 12'd3, h: 12'd1};
    pos[2]    = '{x: 13'sd0, y: 13'sd0};
    sprite[5] = '{x: 12'd100, y: 12'd0, w: 12'd3, h: 12'd1};
    pos[5]    = '{x: 13'sd1, y: 13'sd0};
    run_frame(n);
    checks++; if (n !== 168) begin errors++; $display("FAIL ovl_cycles got %0d exp 168", n); end
    checks++; if (wr_addr_q.size() !== 5) begin errors++; $display("FAIL ovl_writes got %0d exp 5", wr_addr_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (fb_mem[i] !== exp_fb[i]) begin errors++; $display("FAIL ovl_fb%0d got %0h exp %0h", i, fb_mem[i], exp_fb[i]); end
    end
  endtask

  task automatic test_dropped();
    int guard;
    clear_slots();
    @(negedge clk) frame_start = 1'b1;
    @(posedge clk);
    clear_logs();
    @(negedge clk) frame_start = 1'b0;
    repeat (50) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    guard = 0;
    while (dbg_state != S_DRAIN && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (guard >= 1000) begin errors++; $display("FAIL drop_drain_timeout got %0d exp <1000", guard); end
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    repeat (200) @(negedge clk);
    checks++; if (fin_rises !== 1) begin errors++; $display("FAIL drop_rises got %0d exp 1", fin_rises); end
    checks++; if (clr_seen !== 128) begin errors++; $display("FAIL drop_clr got %0d exp 128", clr_seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %b exp 0", busy); end
    checks++; if (painter_finished !== 1'b1) begin errors++; $display("FAIL drop_fin got %b exp 1", painter_finished); end
  endtask

  task automatic test_reset_mid_draw();
    int guard, n;
    clear_slots();
    sprite[0] = '{x: 12'd20, y: 12'd1, w: 12'd8, h: 12'd4};
    pos[0]    = '{x: 13'sd0, y: 13'sd0};
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    guard = 0;
    while (dbg_state != S_DRAW && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (guard >= 1000) begin errors++; $display("FAIL rmd_draw_timeout got %0d exp <1000", guard); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL rmd_we got %b exp 0", fb_we); end
    checks++; if (fb_addr !== '0) begin errors++; $display("FAIL rmd_addr got %0h exp 0", fb_addr); end
    checks++; if (fb_data !== 8'h00) begin errors++; $display("FAIL rmd_data got %0h exp 0", fb_data); end
    checks++; if (rom_addr !== '0) begin errors++; $display("FAIL rmd_rom got %0h exp 0", rom_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmd_busy got %b exp 0", busy); end
    checks++; if (painter_finished !== 1'b0) begin errors++; $display("FAIL rmd_fin got %b exp 0", painter_finished); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    clear_logs();
    repeat (20) @(negedge clk);
    checks++;
    if (wr_addr_q.size() !== 0 || clr_seen !== 0) begin
      errors++;
      $display("FAIL rmd_quiet got wr %0d clr %0d exp 0 0", wr_addr_q.size(), clr_seen);
    end
    run_frame(n);
    checks++; if (n !== 194) begin errors++; $display("FAIL rmd_cycles got %0d exp 194", n); end
    checks++; if (clr_seen !== 128) begin errors++; $display("FAIL rmd_clr got %0d exp 128", clr_seen); end
    checks++; if (clr_err !== 0) begin errors++; $display("FAIL rmd_clr_seq got %0d exp 0", clr_err); end
    checks++; if (wr_addr_q.size() !== 32) begin errors++; $display("FAIL rmd_writes got %0d exp 32", wr_addr_q.size()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clear_slots();
    clear_logs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_empty_frame();
    test_blit();
    test_clip();
    test_overlap();
    test_dropped();
    test_reset_mid_draw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
